// File: rtl/isa_io_target.sv
// ISA I/O-cycle responder: decodes IOW#/IOR# hits in a small port window and
// turns them into single-cycle register-bank requests, stretching reads with IOCHRDY.
module isa_io_target #(
  parameter logic [9:0] BASE_ADDR   = 10'h220,
  parameter int         WINDOW_BITS = 4,
  parameter int         ACK_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [9:0]             sa,
  input  logic                   aen,
  input  logic                   iow_n,
  input  logic                   ior_n,
  input  logic [7:0]             sd_in,
  output logic [7:0]             sd_out,
  output logic                   sd_oe,
  output logic                   iochrdy_hold,
  output logic [WINDOW_BITS-1:0] reg_addr,
  output logic [7:0]             reg_wdata,
  output logic                   reg_wr,
  output logic                   reg_rd,
  input  logic [7:0]             reg_rdata,
  input  logic                   reg_ack,
  output logic                   bus_err
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, RD_DRIVE, RELEASE
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [1:0]             arm_q;
  logic                   iow_s1_q, iow_s2_q, iow_h_q;
  logic                   ior_s1_q, ior_s2_q, ior_h_q;
  logic [7:0]             sd_out_q, sd_out_d;
  logic                   sd_oe_q, sd_oe_d;
  logic                   hold_q, hold_d;
  logic [WINDOW_BITS-1:0] addr_q, addr_d;
  logic [7:0]             wdata_q, wdata_d;
  logic                   wr_q, wr_d;
  logic                   rd_q, rd_d;
  logic                   err_q, err_d;
  logic                   hit, iow_edge, ior_edge;

  // Edges are masked until the synchronizers have flushed their reset value,
  // so a strobe already held low across reset never looks like a new cycle.
  assign hit      = !aen && (sa[9:WINDOW_BITS] == BASE_ADDR[9:WINDOW_BITS]);
  assign iow_edge = (arm_q == 2'd3) && iow_h_q && !iow_s2_q;
  assign ior_edge = (arm_q == 2'd3) && ior_h_q && !ior_s2_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      arm_q    <= 2'd0;
      iow_s1_q <= 1'b1;
      iow_s2_q <= 1'b1;
      iow_h_q  <= 1'b1;
      ior_s1_q <= 1'b1;
      ior_s2_q <= 1'b1;
      ior_h_q  <= 1'b1;
      sd_out_q <= 8'h00;
      sd_oe_q  <= 1'b0;
      hold_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 8'h00;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      if (arm_q != 2'd3) arm_q <= arm_q + 2'd1;
      iow_s1_q <= iow_n;
      iow_s2_q <= iow_s1_q;
      iow_h_q  <= iow_s2_q;
      ior_s1_q <= ior_n;
      ior_s2_q <= ior_s1_q;
      ior_h_q  <= ior_s2_q;
      sd_out_q <= sd_out_d;
      sd_oe_q  <= sd_oe_d;
      hold_q   <= hold_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
    end
  end

  // Outputs are computed for the state being entered, then registered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sd_out_d = sd_out_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    sd_oe_d  = 1'b0;
    hold_d   = 1'b0;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit && iow_edge && ior_edge) begin
          err_d = 1'b1;
        end else if (hit && iow_edge) begin
          addr_d  = sa[WINDOW_BITS-1:0];
          wdata_d = sd_in;
          wr_d    = 1'b1;
          state_d = WR_REQ;
        end else if (hit && ior_edge) begin
          addr_d  = sa[WINDOW_BITS-1:0];
          rd_d    = 1'b1;
          hold_d  = 1'b1;
          state_d = RD_REQ;
        end
      end
      WR_REQ: begin
        cnt_d   = '0;
        state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (reg_ack) begin
          state_d = RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RD_REQ: begin
        cnt_d   = '0;
        hold_d  = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (reg_ack) begin
          sd_out_d = reg_rdata;
          sd_oe_d  = 1'b1;
          state_d  = RD_DRIVE;
        end else if (cnt_q == CNT_LAST) begin
          sd_out_d = 8'hFF;
          sd_oe_d  = 1'b1;
          err_d    = 1'b1;
          state_d  = RD_DRIVE;
        end else begin
          cnt_d  = cnt_q + CNT_ONE;
          hold_d = 1'b1;
        end
      end
      RD_DRIVE: begin
        if (ior_s2_q) state_d = IDLE;
        else          sd_oe_d = 1'b1;
      end
      RELEASE: begin
        if (iow_s2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sd_out       = sd_out_q;
  assign sd_oe        = sd_oe_q;
  assign iochrdy_hold = hold_q;
  assign reg_addr     = addr_q;
  assign reg_wdata    = wdata_q;
  assign reg_wr       = wr_q;
  assign reg_rd       = rd_q;
  assign bus_err      = err_q;

endmodule

// File: tb/tb_isa_io_target.sv
// Directed bench for isa_io_target: write, read, miss/DMA, timeout, collision and reset cases.
module tb_isa_io_target;

  logic       clk;
  logic       reset;
  logic [9:0] sa;
  logic       aen;
  logic       iow_n;
  logic       ior_n;
  logic [7:0] sd_in;
  logic [7:0] sd_out;
  logic       sd_oe;
  logic       iochrdy_hold;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       reg_ack;
  logic       bus_err;

  int nvec = 0;
  int nmis = 0;

  isa_io_target #(.BASE_ADDR(10'h220), .WINDOW_BITS(4), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .sa(sa), .aen(aen), .iow_n(iow_n), .ior_n(ior_n),
    .sd_in(sd_in), .sd_out(sd_out), .sd_oe(sd_oe), .iochrdy_hold(iochrdy_hold),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    nvec++; if (sd_out !== 8'h00) begin nmis++; $display("FAIL rst_sd_out got=%h want=00", sd_out); end
    nvec++; if ({sd_oe, iochrdy_hold, reg_wr, reg_rd, bus_err} !== 5'b0) begin nmis++;
      $display("FAIL rst_ctrl got=%b want=00000", {sd_oe, iochrdy_hold, reg_wr, reg_rd, bus_err}); end
    nvec++; if ({reg_addr, reg_wdata} !== 12'h000) begin nmis++;
      $display("FAIL rst_regs got=%h want=000", {reg_addr, reg_wdata}); end
    reset = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_write_hit();
    int nwr = 0, kwr = 0, nhold = 0, noe = 0, nbe = 0;
    sa = 10'h22C; aen = 1'b0; sd_in = 8'hA5; iow_n = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (reg_wr) begin nwr++; kwr = k; end
      if (iochrdy_hold) nhold++;
      if (sd_oe) noe++;
      if (bus_err) nbe++;
      if (k == 4) reg_ack = 1'b1;
      if (k == 5) reg_ack = 1'b0;
      if (k == 8) iow_n = 1'b1;
    end
    nvec++; if (nwr !== 1) begin nmis++; $display("FAIL wr_count got=%0d want=1", nwr); end
    nvec++; if (kwr !== 3) begin nmis++; $display("FAIL wr_latency got=%0d want=3", kwr); end
    nvec++; if (reg_addr !== 4'hC) begin nmis++; $display("FAIL wr_addr got=%h want=c", reg_addr); end
    nvec++; if (reg_wdata !== 8'hA5) begin nmis++; $display("FAIL wr_data got=%h want=a5", reg_wdata); end
    nvec++; if (nhold !== 0) begin nmis++; $display("FAIL wr_hold got=%0d want=0", nhold); end
    nvec++; if (noe !== 0) begin nmis++; $display("FAIL wr_oe got=%0d want=0", noe); end
    nvec++; if (nbe !== 0) begin nmis++; $display("FAIL wr_err got=%0d want=0", nbe); end
  endtask

  task automatic test_read_wait();
    int nrd = 0, krd = 0, nhold = 0, khold = 0, koe0 = 0, koe1 = 0, nbe = 0;
    logic [7:0] sd9 = 8'h00;
    sa = 10'h223; ior_n = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (reg_rd) begin nrd++; krd = k; end
      if (iochrdy_hold) begin nhold++; if (khold == 0) khold = k; end
      if (sd_oe) begin if (koe0 == 0) koe0 = k; koe1 = k; end
      if (bus_err) nbe++;
      if (k == 9) sd9 = sd_out;
      if (k == 8) begin reg_ack = 1'b1; reg_rdata = 8'h3C; end
      if (k == 9) reg_ack = 1'b0;
      if (k == 12) ior_n = 1'b1;
    end
    nvec++; if (nrd !== 1 || krd !== 3) begin nmis++; $display("FAIL rd_pulse got=%0d@%0d want=1@3", nrd, krd); end
    nvec++; if (khold !== 3 || nhold !== 6) begin nmis++; $display("FAIL rd_hold got=%0d@%0d want=6@3", nhold, khold); end
    nvec++; if (koe0 !== 9) begin nmis++; $display("FAIL rd_oe_rise got=%0d want=9", koe0); end
    nvec++; if (koe1 !== 14) begin nmis++; $display("FAIL rd_oe_fall got=%0d want=14", koe1); end
    nvec++; if (sd9 !== 8'h3C) begin nmis++; $display("FAIL rd_data got=%h want=3c", sd9); end
    nvec++; if (reg_addr !== 4'h3) begin nmis++; $display("FAIL rd_addr got=%h want=3", reg_addr); end
    nvec++; if (nbe !== 0) begin nmis++; $display("FAIL rd_err got=%0d want=0", nbe); end
  endtask

  task automatic test_miss_dma();
    int nact = 0;
    sa = 10'h230; aen = 1'b0; ior_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (reg_rd || reg_wr || sd_oe || iochrdy_hold || bus_err) nact++;
      if (k == 4) ior_n = 1'b1;
    end
    sa = 10'h221; aen = 1'b1; sd_in = 8'h77; iow_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (reg_rd || reg_wr || sd_oe || iochrdy_hold || bus_err) nact++;
      if (k == 4) iow_n = 1'b1;
    end
    aen = 1'b0;
    nvec++; if (nact !== 0) begin nmis++; $display("FAIL miss_activity got=%0d want=0", nact); end
    nvec++; if ({reg_addr, reg_wdata} !== 12'h3A5) begin nmis++;
      $display("FAIL miss_regs got=%h want=3a5", {reg_addr, reg_wdata}); end
  endtask

  task automatic test_timeout();
    int nhold = 0, khold = 0, nbe = 0, kbe = 0;
    logic [7:0] sd19 = 8'h00;
    logic oe19 = 1'b0;
    sa = 10'h220; ior_n = 1'b0;
    for (int k = 1; k <= 28; k++) begin
      tick();
      if (iochrdy_hold) begin nhold++; if (khold == 0) khold = k; end
      if (bus_err) begin nbe++; kbe = k; end
      if (k == 19) begin sd19 = sd_out; oe19 = sd_oe; end
      if (k == 22) ior_n = 1'b1;
    end
    nvec++; if (khold !== 3 || nhold !== 16) begin nmis++; $display("FAIL to_hold got=%0d@%0d want=16@3", nhold, khold); end
    nvec++; if (nbe !== 1 || kbe !== 19) begin nmis++; $display("FAIL to_err got=%0d@%0d want=1@19", nbe, kbe); end
    nvec++; if (sd19 !== 8'hFF || oe19 !== 1'b1) begin nmis++; $display("FAIL to_drive got=%h/%b want=ff/1", sd19, oe19); end
    nvec++; if (sd_oe !== 1'b0) begin nmis++; $display("FAIL to_release got=%b want=0", sd_oe); end
  endtask

  task automatic test_fast_read();
    int nact = 0, nhold = 0, koe0 = 0, koe1 = 0;
    logic [7:0] sd5 = 8'h00;
    sa = 10'h22F; reg_rdata = 8'h99; reg_ack = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (sd_oe || iochrdy_hold || reg_rd || bus_err) nact++;
    end
    reg_ack = 1'b0; ior_n = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (iochrdy_hold) nhold++;
      if (sd_oe) begin if (koe0 == 0) koe0 = k; koe1 = k; end
      if (k == 5) sd5 = sd_out;
      if (k == 4) begin reg_ack = 1'b1; reg_rdata = 8'h5A; end
      if (k == 5) reg_ack = 1'b0;
      if (k == 6) ior_n = 1'b1;
    end
    nvec++; if (nact !== 0) begin nmis++; $display("FAIL idle_ack got=%0d want=0", nact); end
    nvec++; if (nhold !== 2) begin nmis++; $display("FAIL fast_hold got=%0d want=2", nhold); end
    nvec++; if (koe0 !== 5 || koe1 !== 8) begin nmis++; $display("FAIL fast_oe got=%0d..%0d want=5..8", koe0, koe1); end
    nvec++; if (sd5 !== 8'h5A) begin nmis++; $display("FAIL fast_data got=%h want=5a", sd5); end
  endtask

  task automatic test_simultaneous();
    int nreq = 0, nbe = 0, kbe = 0;
    sa = 10'h225; iow_n = 1'b0; ior_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (reg_rd || reg_wr || iochrdy_hold || sd_oe) nreq++;
      if (bus_err) begin nbe++; kbe = k; end
      if (k == 5) begin iow_n = 1'b1; ior_n = 1'b1; end
    end
    nvec++; if (nbe !== 1 || kbe !== 3) begin nmis++; $display("FAIL sim_err got=%0d@%0d want=1@3", nbe, kbe); end
    nvec++; if (nreq !== 0) begin nmis++; $display("FAIL sim_req got=%0d want=0", nreq); end
  endtask

  task automatic test_reset_mid_read();
    int nrd = 0, krd = 0, koe0 = 0;
    logic [4:0] ctl6 = 5'h1F;
    logic [7:0] sd6 = 8'hFF, sd5 = 8'h00;
    sa = 10'h224; ior_n = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 6) begin ctl6 = {sd_oe, iochrdy_hold, reg_wr, reg_rd, bus_err}; sd6 = sd_out; end
      if (k >= 7 && reg_rd) nrd++;
      if (k == 5) reset = 1'b0;
      if (k == 6) reset = 1'b1;
      if (k == 20) ior_n = 1'b1;
    end
    nvec++; if (ctl6 !== 5'b0) begin nmis++; $display("FAIL mid_rst_ctrl got=%b want=00000", ctl6); end
    nvec++; if (sd6 !== 8'h00) begin nmis++; $display("FAIL mid_rst_sd got=%h want=00", sd6); end
    nvec++; if (nrd !== 0) begin nmis++; $display("FAIL mid_rst_held got=%0d want=0", nrd); end
    nrd = 0;
    ior_n = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (reg_rd) begin nrd++; krd = k; end
      if (sd_oe && koe0 == 0) koe0 = k;
      if (k == 5) sd5 = sd_out;
      if (k == 4) begin reg_ack = 1'b1; reg_rdata = 8'h81; end
      if (k == 5) reg_ack = 1'b0;
      if (k == 7) ior_n = 1'b1;
    end
    nvec++; if (nrd !== 1 || krd !== 3) begin nmis++; $display("FAIL retoggle_rd got=%0d@%0d want=1@3", nrd, krd); end
    nvec++; if (koe0 !== 5 || sd5 !== 8'h81) begin nmis++; $display("FAIL retoggle_data got=%0d/%h want=5/81", koe0, sd5); end
  endtask

  initial begin
    reset = 1'b0; sa = 10'h000; aen = 1'b0; iow_n = 1'b1; ior_n = 1'b1;
    sd_in = 8'h00; reg_rdata = 8'h00; reg_ack = 1'b0;
    test_reset();
    test_write_hit();
    test_read_wait();
    test_miss_dma();
    test_timeout();
    test_fast_read();
    test_simultaneous();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/isa_io_target.md
# isa_io_target

ISA I/O-cycle responder: decodes host IOW#/IOR# cycles aimed at a 16-port window, turns each into a single-cycle write or read request to the card's internal register bank, and returns read data on SD. It holds IOCHRDY low (wait states) until the register bank answers. It sits on the card side of the riser, opposite the bus-cycle generator that produces IOR#/IOW# pulses.

## Interface
- BASE_ADDR, 10'h220: window base; low WINDOW_BITS bits ignored
- WINDOW_BITS, 4: port window size is 2^WINDOW_BITS
- ACK_TIMEOUT, 15: maximum cycles spent waiting for reg_ack (≥2)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- sa  in  10  ISA address
- aen  in  1  DMA address enable; decode only when 0
- iow_n  in  1  ISA I/O write strobe, asynchronous
- ior_n  in  1  ISA I/O read strobe, asynchronous
- sd_in  in  8  ISA data, write direction
- sd_out  out  8  ISA read data
- sd_oe  out  1  SD output enable
- iochrdy_hold  out  1  1 = drive IOCHRDY low (insert wait)
- reg_addr  out  WINDOW_BITS  register index
- reg_wdata  out  8  write data
- reg_wr  out  1  write request, one-cycle pulse
- reg_rd  out  1  read request, one-cycle pulse
- reg_rdata  in  8  read data, valid with reg_ack
- reg_ack  in  1  register bank completion
- bus_err  out  1  one-cycle pulse: timeout or simultaneous strobes

## Operation
- iow_n and ior_n each pass through a 2-flop synchronizer plus a history flop. All three reset to 1. A falling edge means history=1 and sync2=0.
- hit = (aen==0) && (sa[9:WINDOW_BITS] == BASE_ADDR[9:WINDOW_BITS]). It is evaluated in the cycle the edge is detected.
- States: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, RD_DRIVE, RELEASE.
- IDLE transitions:
  - iow edge and hit: latch sa[WINDOW_BITS-1:0]→reg_addr and sd_in→reg_wdata, then go to WR_REQ.
  - ior edge and hit: latch reg_addr, then go to RD_REQ.
  - Both edges in the same cycle: bus_err pulse, stay in IDLE.
  - Miss: stay in IDLE, no outputs change.
- WR_REQ: reg_wr=1 for one cycle, clear the timeout counter, go to WR_WAIT. Writes are posted, so iochrdy_hold stays 0.
- WR_WAIT:
  - reg_ack: go to RELEASE.
  - cnt==ACK_TIMEOUT-1 without ack: bus_err pulse, go to RELEASE.
  - Otherwise: cnt++.
- RD_REQ: reg_rd=1 for one cycle, iochrdy_hold=1, clear the counter, go to RD_WAIT.
- RD_WAIT: iochrdy_hold=1.
  - reg_ack: sd_out←reg_rdata, go to RD_DRIVE.
  - Timeout (same rule as WR_WAIT): sd_out←8'hFF, bus_err pulse, go to RD_DRIVE.
- RD_DRIVE: sd_oe=1, iochrdy_hold=0, sd_out held. When synchronized ior_n reads 1, go to IDLE (sd_oe falls).
- RELEASE: when synchronized iow_n reads 1, go to IDLE.
- reg_ack outside the *_WAIT states is ignored.
- If ACK_TIMEOUT WAIT cycles pass, the last one is still checked for ack; ack wins over timeout in that cycle.
- Strobes in states other than IDLE are ignored. No new cycle starts until the current one has returned to IDLE.

## Timing
- All outputs are registered.
- Reset values: sd_out=8'h00; every other output 0; state IDLE; counter 0.
- Edge E is the first clk edge that samples the strobe low.
  - Edge detect is combinational after E+1.
  - The FSM enters *_REQ at E+2: reg_wr/reg_rd is high for the cycle E+2..E+3, and iochrdy_hold rises at E+2.
- If ack arrives in the first WAIT cycle (E+3..E+4):
  - RD_DRIVE at E+4: sd_oe=1 and iochrdy_hold=0 at the same edge.
  - Write RELEASE at E+4.
- Timeout read: RD_DRIVE at E+3+ACK_TIMEOUT.
- sd_oe deasserts 3 edges after ior_n rises (2 synchronizer edges plus the state update).
- Reset mid-transaction: at the next edge, sd_oe, iochrdy_hold, reg_wr and reg_rd all go to 0. A strobe still held low afterwards creates no edge and is ignored until it rises and falls again.
- The counter is $clog2(ACK_TIMEOUT+1) bits wide and never wraps (it is cleared on every WAIT entry).

## Test plan
- Write hit: sa=10'h22C, aen=0, sd_in=8'hA5, iow_n low for 8 clks, ack at E+3. Expect reg_wr pulse at E+2, reg_addr=4'hC, reg_wdata=8'hA5, no iochrdy_hold, bus_err=0.
- Read hit with wait: sa=10'h223, reg_ack 5 cycles after reg_rd with reg_rdata=8'h3C. Expect iochrdy_hold high from E+2 until RD_DRIVE, sd_out=8'h3C, sd_oe high until 3 edges after ior_n rises.
- Miss/DMA: sa=10'h230 with ior_n pulse; then sa=10'h221, aen=1 with iow_n pulse. Expect no reg_rd/reg_wr, sd_oe=0, iochrdy_hold=0.
- Timeout: read at 10'h220, reg_ack never asserted. Expect bus_err pulse, sd_out=8'hFF, iochrdy_hold high for exactly ACK_TIMEOUT+1 cycles (RD_REQ plus WAIT).
- Simultaneous: iow_n and ior_n fall in the same cycle at a hit address. Expect bus_err pulse, no requests, state IDLE.
- Reset mid-read: assert reset during RD_WAIT. Expect all outputs 0 next edge; with ior_n still low, no new reg_rd until ior_n toggles high then low.
